// File: rtl/patch_extractor_pkg.sv
// Shared defaults and sizing helpers for the binary KxK patch extractor.
package patch_extractor_pkg;

  localparam int unsigned DefImgWidth   = 28;
  localparam int unsigned DefImgHeight  = 28;
  localparam int unsigned DefKernelSize = 3;
  localparam int unsigned DefPatchSize  = DefKernelSize * DefKernelSize;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefXWidth = cnt_width(DefImgWidth);
  localparam int unsigned DefYWidth = cnt_width(DefImgHeight);

endpackage

// File: rtl/line_buffer.sv
// One image row of 1-bit pixels; q_o is the pixel accepted Depth enables ago.
module line_buffer #(
  parameter int unsigned Depth = 28
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic [Depth-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en_i) begin
      sr_d = {sr_q[Depth-2:0], d_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[Depth-1];

endmodule

// File: rtl/patch_extractor_28x28.sv
// Streaming KxK window extractor over a raster-order binary image.
module patch_extractor_28x28
  import patch_extractor_pkg::*;
#(
  parameter int unsigned IMG_WIDTH   = DefImgWidth,
  parameter int unsigned IMG_HEIGHT  = DefImgHeight,
  parameter int unsigned KERNEL_SIZE = DefKernelSize
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 pixel_in,
  input  logic                                 valid_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE-1:0]   patch_out,
  output logic                                 valid_out
);

  localparam int unsigned XW = cnt_width(IMG_WIDTH);
  localparam int unsigned YW = cnt_width(IMG_HEIGHT);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          valid_q, valid_d;

  logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0] win_q, win_d;
  logic [KERNEL_SIZE-1:0]                  col;
  logic [KERNEL_SIZE-2:0]                  lb_in, lb_out;

  // Buffers are chained: buffer j outputs the pixel j+1 rows above the current one.
  for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_lb
    if (j == 0) begin : g_head
      assign lb_in[j] = pixel_in;
    end else begin : g_chain
      assign lb_in[j] = lb_out[j-1];
    end
    line_buffer #(
      .Depth(IMG_WIDTH)
    ) u_line_buffer (
      .clk_i (clk),
      .rst_ni(reset),
      .en_i  (valid_in),
      .d_i   (lb_in[j]),
      .q_o   (lb_out[j])
    );
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (valid_in) begin
      if (x_q == XW'(IMG_WIDTH - 1)) begin
        x_d = '0;
        if (y_q == YW'(IMG_HEIGHT - 1)) begin
          y_d = '0;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  assign valid_d = valid_in && (x_q >= XW'(KERNEL_SIZE - 1)) && (y_q >= YW'(KERNEL_SIZE - 1));

  // Row 0 of the window is the oldest row; column 0 is the newest column.
  always_comb begin
    col[KERNEL_SIZE-1] = pixel_in;
    for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
      col[r] = lb_out[KERNEL_SIZE-2-r];
    end
    win_d = win_q;
    if (valid_in) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        win_d[r] = {win_q[r][KERNEL_SIZE-2:0], col[r]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  assign patch_out = win_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_patch_extractor_28x28.sv
// Directed checks of the 28x28 / K=3 patch extractor on a quadrant test image.
module tb_patch_extractor_28x28;

  localparam int W = 28;
  localparam int H = 28;
  localparam int NPIX = W * H;
  localparam int NPATCH = 676;

  logic       clk;
  logic       reset;
  logic       pixel_in;
  logic       valid_in;
  logic [8:0] patch_out;
  logic       valid_out;

  int checks;
  int errors;
  int idx;
  int last_idx;
  bit cap_en;
  logic [8:0] cap_q[$];
  logic [8:0] ref_q[$];
  int         cap_idx[$];

  patch_extractor_28x28 #(
    .IMG_WIDTH  (28),
    .IMG_HEIGHT (28),
    .KERNEL_SIZE(3)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .pixel_in (pixel_in),
    .valid_in (valid_in),
    .patch_out(patch_out),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_en && valid_out) begin
      cap_q.push_back(patch_out);
      cap_idx.push_back(last_idx);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic pix(input int y, input int x);
    return (y < 14) && (x < 14);
  endfunction

  function automatic logic [8:0] model(input int y, input int x);
    logic [8:0] m;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        m[3*r+k] = pix(y - 2 + r, x - k);
      end
    end
    return m;
  endfunction

  // One clock: present inputs, take the edge, then check idle-cycle behaviour.
  task automatic step(input logic v, input logic p);
    logic [8:0] pre;
    pixel_in = p;
    valid_in = v;
    pre = patch_out;
    @(posedge clk);
    #1;
    if (v) begin
      last_idx = idx;
      idx++;
    end else begin
      check_eq("gap_valid_out", {31'd0, valid_out}, 32'd0);
      check_eq("gap_patch_hold", {23'd0, patch_out}, {23'd0, pre});
    end
  endtask

  task automatic run_frame(input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) step(1'b0, 1'b0);
      if (gaps && ($urandom_range(0, 9) == 0)) begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
      end
      step(1'b1, pix(i / W, i % W));
    end
    step(1'b0, 1'b0);
  endtask

  task automatic clear_capture();
    cap_q.delete();
    cap_idx.delete();
    idx = 0;
    cap_en = 1'b1;
  endtask

  task automatic cmp_model(input string tag, input int base);
    for (int n = 0; n < NPATCH && (base + n) < cap_q.size(); n++) begin
      check_eq(tag, {23'd0, cap_q[base+n]}, {23'd0, model(2 + n / 26, 2 + n % 26)});
    end
  endtask

  task automatic check_edges(input string tag);
    int bad;
    bad = 0;
    foreach (cap_idx[i]) begin
      if ((cap_idx[i] % W) < 2 || ((cap_idx[i] / W) % H) < 2) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    idx      = 0;
    last_idx = 0;
    cap_en   = 1'b0;
    pixel_in = 1'b0;
    valid_in = 1'b0;
    reset    = 1'b0;
    #23;
    check_eq("reset_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("reset_patch_out", {23'd0, patch_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Gap-free frame
    clear_capture();
    run_frame(1'b0);
    cap_en = 1'b0;
    check_eq("count_plain", cap_q.size(), NPATCH);
    if (cap_q.size() == NPATCH) begin
      check_eq("first_idx", cap_idx[0], 58);
      check_eq("patch_2_2", {23'd0, cap_q[0]}, 32'h1FF);
      check_eq("patch_2_15", {23'd0, cap_q[13]}, 32'h124);
      check_eq("patch_15_2", {23'd0, cap_q[338]}, 32'h007);
      check_eq("patch_27_27", {23'd0, cap_q[675]}, 32'h000);
    end
    cmp_model("model_plain", 0);
    check_edges("edge_plain");
    ref_q = cap_q;

    // Same frame with random idle cycles
    clear_capture();
    run_frame(1'b1);
    cap_en = 1'b0;
    check_eq("count_gaps", cap_q.size(), NPATCH);
    for (int n = 0; n < NPATCH && n < cap_q.size() && n < ref_q.size(); n++) begin
      check_eq("gaps_vs_plain", {23'd0, cap_q[n]}, {23'd0, ref_q[n]});
    end

    // Reset in the middle of a frame
    clear_capture();
    for (int i = 0; i < 300; i++) step(1'b1, pix(i / W, i % W));
    check_eq("pre_reset_valid", {31'd0, valid_out}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("midreset_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("midreset_patch_out", {23'd0, patch_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    clear_capture();
    run_frame(1'b0);
    cap_en = 1'b0;
    check_eq("count_after_reset", cap_q.size(), NPATCH);
    if (cap_idx.size() > 0) check_eq("first_idx_after_reset", cap_idx[0], 58);
    cmp_model("model_after_reset", 0);

    // Two frames back to back
    clear_capture();
    for (int i = 0; i < 2 * NPIX; i++) step(1'b1, pix((i % NPIX) / W, i % W));
    step(1'b0, 1'b0);
    cap_en = 1'b0;
    check_eq("count_b2b", cap_q.size(), 2 * NPATCH);
    cmp_model("model_b2b_f0", 0);
    cmp_model("model_b2b_f1", NPATCH);
    check_edges("edge_b2b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/patch_extractor_28x28.md
PATCH_EXTRACTOR_28X28 -- requirements
Module: patch_extractor_28x28

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 28: pixels per image row.
REQ-002 SHALL have parameter IMG_HEIGHT, default 28: rows per image.
REQ-003 SHALL have parameter KERNEL_SIZE, default 3: window edge K (K>=2); local PATCH_SIZE = K*K.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pixel_in, input, 1: binary pixel, raster order (row-major, left to right).
REQ-007 SHALL have port valid_in, input, 1: pixel_in is valid this cycle.
REQ-008 SHALL have port patch_out, output, PATCH_SIZE: current KxK window.
REQ-009 SHALL have port valid_out, output, 1: patch_out holds a complete in-image window.

Function
REQ-010 SHALL keep column counter x (0..IMG_WIDTH-1) and row counter y (0..IMG_HEIGHT-1), advanced only on valid_in=1 cycles.
REQ-011 SHALL increment x on each accepted pixel and wrap x to 0 at IMG_WIDTH-1 while incrementing y; at (IMG_HEIGHT-1, IMG_WIDTH-1) both SHALL wrap to 0 for the next frame.
REQ-012 SHALL store the previous K-1 image rows in line buffers of IMG_WIDTH bits each, written only on accepted pixels.
REQ-013 SHALL shift a KxK window register one column per accepted pixel, the new column taken from the line buffers (older rows) plus pixel_in (newest row).
REQ-014 SHALL map bits as patch_out[K*r + k] = pixel(y-(K-1)+r, x-k), r=0 top row, k=0 rightmost column; for K=3 bit 6 = current pixel, bit 2 = top-left.
REQ-015 SHALL assert valid_out for exactly one cycle, the cycle after an accepted pixel with y>=K-1 and x>=K-1; patch_out SHALL update on that same edge.
REQ-016 SHALL give latency 1 clock from the accepted completing pixel to valid_out/patch_out.
REQ-017 SHALL never assert valid_out for windows crossing the left image edge (x<K-1) or the top edge (y<K-1); no padding.
REQ-018 SHALL produce (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) patches per frame (676 for 28x28, K=3).
REQ-019 SHALL hold all state and drive valid_out=0 on cycles following valid_in=0; patch_out SHALL hold its last value; gaps of any length SHALL not alter results.
REQ-020 SHALL keep no backpressure; every valid_out pulse must be consumed that cycle.

Reset
REQ-021 SHALL, on reset low, clear x, y, line buffers, window register, patch_out to 0 and valid_out to 0 asynchronously.
REQ-022 SHALL, after reset mid-frame, treat the next accepted pixel as (0,0) of a new frame.

Structure
REQ-023 SHALL place default IMG_WIDTH, IMG_HEIGHT, KERNEL_SIZE and derived PATCH_SIZE / counter widths in shared package patch_extractor_pkg.
REQ-024 SHALL implement each row store as sub-module line_buffer (IMG_WIDTH-deep 1-bit shift/circular buffer with enable), instantiated K-1 times.

Verification
REQ-025 SHALL verify: 28x28 frame, pixel=1 where row<14 and col<14, continuous valid_in -> exactly 676 valid_out pulses, first one cycle after pixel index 58, patch_out=9'h1FF.
REQ-026 SHALL verify: same frame, window ending at (2,15) -> patch_out=9'b100100100 (0x124); at (15,2) -> 9'h007; at (27,27) -> 9'h000.
REQ-027 SHALL verify: random valid_in gaps (e.g. 1 of 3 cycles low) -> same 676 patch values in same order as gap-free run.
REQ-028 SHALL verify: reset low at pixel index 300 -> valid_out=0 and patch_out=0 immediately; fresh frame afterwards yields 676 correct patches.
REQ-029 SHALL verify: two back-to-back frames -> no valid_out for x<2 or y<2 of the second frame; second frame patches match the first.
